// File: rtl/controle_mips.sv
// Main control unit for the single-cycle MIPS-subset datapath.
// Registers decode(opcode) each clock; sync active-high reset clears all.
package controle_mips_pkg;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_ADDI  = 3'b001,
    OP_LOGI  = 3'b010,
    OP_LW    = 3'b011,
    OP_SW    = 3'b100,
    OP_BEQ   = 3'b101,
    OP_J     = 3'b110,
    OP_JAL   = 3'b111
  } op_t;

  typedef struct packed {
    logic [1:0] ula_opcode;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       ula_src;
    logic       mem_escrita;
    logic       mem_leitura;
    logic       reg_escrita;
    logic       branch;
    logic       jump;
    logic       sign_zero;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    // X/Z opcodes fall through to the all-zero default
    case (op)
      OP_RTYPE: begin
        c.ula_opcode  = 2'b10;
        c.reg_dest    = 2'b01;
        c.reg_escrita = 1'b1;
      end
      OP_ADDI: begin
        c.ula_src     = 1'b1;
        c.reg_escrita = 1'b1;
        c.sign_zero   = 1'b1;
      end
      OP_LOGI: begin
        c.ula_opcode  = 2'b11;
        c.ula_src     = 1'b1;
        c.reg_escrita = 1'b1;
      end
      OP_LW: begin
        c.ula_src     = 1'b1;
        c.mem_leitura = 1'b1;
        c.mem_to_reg  = 2'b01;
        c.reg_escrita = 1'b1;
        c.sign_zero   = 1'b1;
      end
      OP_SW: begin
        c.ula_src     = 1'b1;
        c.mem_escrita = 1'b1;
        c.sign_zero   = 1'b1;
      end
      OP_BEQ: begin
        c.ula_opcode = 2'b01;
        c.branch     = 1'b1;
        c.sign_zero  = 1'b1;
      end
      OP_J: begin
        c.jump = 1'b1;
      end
      OP_JAL: begin
        c.jump        = 1'b1;
        c.reg_dest    = 2'b10;
        c.mem_to_reg  = 2'b10;
        c.reg_escrita = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

module controle_mips
  import controle_mips_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  output logic [1:0] ula_opcode,
  output logic [1:0] reg_dest,
  output logic [1:0] mem_to_reg,
  output logic       ula_src,
  output logic       mem_escrita,
  output logic       mem_leitura,
  output logic       reg_escrita,
  output logic       branch,
  output logic       jump,
  output logic       sign_zero
);

  ctrl_t ctrl;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl <= '0;
    end else begin
      ctrl <= decode(opcode);
    end
  end

  assign ula_opcode  = ctrl.ula_opcode;
  assign reg_dest    = ctrl.reg_dest;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign ula_src     = ctrl.ula_src;
  assign mem_escrita = ctrl.mem_escrita;
  assign mem_leitura = ctrl.mem_leitura;
  assign reg_escrita = ctrl.reg_escrita;
  assign branch      = ctrl.branch;
  assign jump        = ctrl.jump;
  assign sign_zero   = ctrl.sign_zero;

endmodule

// File: tb/tb_controle_mips.sv
// Scoreboard bench for controle_mips: driver pushes model results,
// monitor pops one per edge and compares against the registered outputs.
module tb_controle_mips;

  logic       clock;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] ula_opcode;
  logic [1:0] reg_dest;
  logic [1:0] mem_to_reg;
  logic       ula_src;
  logic       mem_escrita;
  logic       mem_leitura;
  logic       reg_escrita;
  logic       branch;
  logic       jump;
  logic       sign_zero;

  int checks;
  int failures;
  bit done;

  logic [12:0] sb_q[$];

  controle_mips dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .ula_opcode (ula_opcode),
    .reg_dest   (reg_dest),
    .mem_to_reg (mem_to_reg),
    .ula_src    (ula_src),
    .mem_escrita(mem_escrita),
    .mem_leitura(mem_leitura),
    .reg_escrita(reg_escrita),
    .branch     (branch),
    .jump       (jump),
    .sign_zero  (sign_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference built from instruction classes rather than a per-row table
  function automatic logic [12:0] model(input bit rst, input int op);
    bit is_r, is_imm_alu, is_load, is_store, is_br, is_jmp, links, writes;
    logic [1:0] alu, dst, wb;
    bit src, sx;
    if (rst) return 13'd0;
    is_r       = (op == 0);
    is_imm_alu = (op == 1) || (op == 2);
    is_load    = (op == 3);
    is_store   = (op == 4);
    is_br      = (op == 5);
    is_jmp     = (op >= 6);
    links      = (op == 7);
    writes     = is_r || is_imm_alu || is_load || links;
    src        = is_imm_alu || is_load || is_store;
    sx         = (src && op != 2) || is_br;
    alu = is_r ? 2'd2 : (op == 2) ? 2'd3 : is_br ? 2'd1 : 2'd0;
    dst = is_r ? 2'd1 : links ? 2'd2 : 2'd0;
    wb  = is_load ? 2'd1 : links ? 2'd2 : 2'd0;
    return {alu, dst, wb, src, is_store, is_load, writes,
            is_br, is_jmp, sx};
  endfunction

  task automatic drive(input bit rst, input int op);
    @(negedge clock);
    reset  = rst;
    opcode = 3'(op);
    sb_q.push_back(model(rst, op));
  endtask

  // Monitor: one registered result per rising edge
  initial begin : monitor
    logic [12:0] act, exp;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        act = {ula_opcode, reg_dest, mem_to_reg, ula_src, mem_escrita,
               mem_leitura, reg_escrita, branch, jump, sign_zero};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL decode t=%0t actual=%b required=%b",
                   $time, act, exp);
        end
        checks++;
        if (mem_escrita === 1'b1 && mem_leitura === 1'b1) begin
          failures++;
          $display("FAIL mem_rw_excl actual=11 required=not both");
        end
        checks++;
        if (branch === 1'b1 && jump === 1'b1) begin
          failures++;
          $display("FAIL br_jmp_excl actual=11 required=not both");
        end
        checks++;
        if (reg_escrita === 1'b1 &&
            (mem_escrita === 1'b1 || branch === 1'b1 ||
             (jump === 1'b1 && reg_dest !== 2'b10))) begin
          failures++;
          $display("FAIL no_write actual=reg_escrita=1 required=0");
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset  = 1'b1;
    opcode = 3'b011;
    checks = 0;
    failures = 0;
    done = 1'b0;
    repeat (5) drive(1, 3);
    drive(0, 3);
    for (int i = 0; i < 8; i++) drive(0, i);
    drive(0, 4);
    drive(0, 5);
    drive(0, 7);
    drive(0, 2);
    drive(0, 1);
    drive(1, 7);
    drive(0, 7);
    drive(1, 0);
    drive(1, 5);
    drive(0, 0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
    end
    @(negedge clock);
    @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_mips.md
Name: controle_mips

Overview:
- Main control unit of the single-cycle MIPS-subset datapath.
- Decodes the 3-bit instruction opcode into the datapath control signals: ALU operation class, destination-register select, write-back select, ALU operand source, memory read/write, register write, branch, jump, immediate extension mode.
- Outputs are registered: one clock, synchronous active-high reset.
- Sits between the instruction register and the datapath muxes, ALU control, data memory and register file.

Parameters:
- None. Opcode width is fixed at 3 bits and the decode table is fixed.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; forces all outputs to 0.
- opcode  input  3  instruction opcode field.
- ula_opcode  output  2  ALU op class: 00 add, 01 subtract (compare), 10 R-type (use funct), 11 logical immediate.
- reg_dest  output  2  write-register select: 00 rt, 01 rd, 10 $ra (reg 31), 11 unused.
- mem_to_reg  output  2  write-back select: 00 ALU result, 01 memory data, 10 PC+4, 11 unused.
- ula_src  output  1  ALU operand B: 0 register rt, 1 extended immediate.
- mem_escrita  output  1  data memory write enable.
- mem_leitura  output  1  data memory read enable.
- reg_escrita  output  1  register file write enable.
- branch  output  1  conditional branch (taken if ALU zero).
- jump  output  1  unconditional jump.
- sign_zero  output  1  immediate extension: 1 sign-extend, 0 zero-extend.

Behaviour:
- All outputs are flops updated on the rising edge of clock. There is no combinational path from opcode to outputs.
- Reset:
  - If reset=1 at an edge, every output becomes 0 on that edge (all 2-bit outputs 00, all 1-bit outputs 0).
  - Reset has priority over opcode.
  - Outputs hold 0 while reset stays high.
  - Reset asserted mid-stream clears the outputs on the next edge, regardless of the previous opcode.
- Normal operation (reset=0): outputs take decode(opcode) on each edge. Latency is exactly 1 cycle.
- Outputs are undefined (X) before the first edge; the bench must apply reset first.
- Decode table. Every field not listed is 0/00.
  - 000 R-type: ula_opcode=10, reg_dest=01, reg_escrita=1.
  - 001 ADDI: ula_opcode=00, ula_src=1, reg_escrita=1, sign_zero=1.
  - 010 ORI/ANDI (logical imm): ula_opcode=11, ula_src=1, reg_escrita=1, sign_zero=0.
  - 011 LW: ula_opcode=00, ula_src=1, mem_leitura=1, mem_to_reg=01, reg_escrita=1, sign_zero=1.
  - 100 SW: ula_opcode=00, ula_src=1, mem_escrita=1, sign_zero=1.
  - 101 BEQ: ula_opcode=01, branch=1, sign_zero=1.
  - 110 J: jump=1.
  - 111 JAL: jump=1, reg_dest=10, mem_to_reg=10, reg_escrita=1.
- Invariants:
  - mem_escrita and mem_leitura never both 1.
  - branch and jump never both 1.
  - reg_escrita=0 whenever mem_escrita, branch, or jump-without-link is set.
- An X/Z opcode while reset=0 drives all outputs to 0 (safe default branch of the decoder).

Test Plan:
- Hold reset=1 for 5 edges with opcode=011 -> all outputs 0 throughout. Release reset -> next edge gives mem_leitura=1, mem_to_reg=01, ula_src=1, reg_escrita=1, sign_zero=1.
- Sweep opcode 000..111, one per cycle, reset=0 -> each cycle's outputs equal the table row for the opcode applied one edge earlier. Check R-type: ula_opcode=10, reg_dest=01, reg_escrita=1, rest 0.
- Apply 100 (SW) -> mem_escrita=1, reg_escrita=0, mem_leitura=0. Apply 101 (BEQ) -> branch=1, ula_opcode=01, reg_escrita=0.
- Apply 111 (JAL) -> jump=1, reg_dest=10, mem_to_reg=10, reg_escrita=1, branch=0.
- Apply 010 then 001 -> sign_zero toggles 0 then 1, ula_opcode 11 then 00, ula_src=1 both cycles.
- After the sweep, assert reset=1 with opcode=111 -> outputs 0 on the next edge. Deassert -> JAL decode reappears one edge later.
